// File: rtl/upload_arbiter_pkg.sv
// Shared encodings for the upload arbiter: flit ctrl codes, dc routing bit, one-hot FSM states.
// The round-robin tie-break is enabled by defining UPLOAD_ARB_RR_EN.
package upload_arbiter_pkg;

   localparam int unsigned FLIT_W       = 16;
   localparam int unsigned CTRL_W       = 2;
   localparam int unsigned STATE_W      = 3;
   localparam int unsigned DC_ROUTE_BIT = 15;

   localparam logic [CTRL_W-1:0] CTRL_NONE = 2'b00;
   localparam logic [CTRL_W-1:0] CTRL_HEAD = 2'b01;
   localparam logic [CTRL_W-1:0] CTRL_BODY = 2'b10;
   localparam logic [CTRL_W-1:0] CTRL_TAIL = 2'b11;

   // Generic two-requester channel states; requester A / B are bound per channel below.
   localparam logic [STATE_W-1:0] ST_IDLE   = 3'b001;
   localparam logic [STATE_W-1:0] ST_A_SEND = 3'b010;
   localparam logic [STATE_W-1:0] ST_B_SEND = 3'b100;

   localparam logic [STATE_W-1:0] REQ_IDLE     = ST_IDLE;
   localparam logic [STATE_W-1:0] REQ_IC_SEND  = ST_A_SEND;
   localparam logic [STATE_W-1:0] REQ_DC_SEND  = ST_B_SEND;
   localparam logic [STATE_W-1:0] REP_IDLE     = ST_IDLE;
   localparam logic [STATE_W-1:0] REP_DC_SEND  = ST_A_SEND;
   localparam logic [STATE_W-1:0] REP_MEM_SEND = ST_B_SEND;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [FLIT_W-1:0] data;
   } flit_t;

   function automatic logic is_stray(input logic [CTRL_W-1:0] ctrl);
      return (ctrl == CTRL_BODY) || (ctrl == CTRL_TAIL);
   endfunction

endpackage

// File: rtl/chan_arb2.sv
// Two-requester packet-locking arbiter for one network channel; zero-cycle head forwarding.
// With UPLOAD_ARB_RR_EN a 1-bit pointer replaces the fixed tie-break (TIE_B).
module chan_arb2
   import upload_arbiter_pkg::*;
#(
   parameter bit TIE_B = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               head_a,
   input  logic               head_b,
   input  logic               v_a,
   input  logic               v_b,
   input  flit_t              in_a,
   input  flit_t              in_b,
   input  logic               rdy,
   output logic               ack_a,
   output logic               ack_b,
   output logic               v,
   output flit_t              out,
   output logic [STATE_W-1:0] state
);

   logic [STATE_W-1:0] state_nx;
   logic               tie_b;
   logic               pick_b;

`ifdef UPLOAD_ARB_RR_EN
   logic ptr_b;
   logic ptr_b_nx;

   always_ff @(posedge clk) begin
      if (rst) ptr_b <= TIE_B;
      else     ptr_b <= ptr_b_nx;
   end

   assign tie_b = ptr_b;
`else
   assign tie_b = TIE_B;
`endif

   assign pick_b = head_b && (!head_a || tie_b);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Grant in IDLE, then forward the locked requester until its tail moves.
   always_comb begin
      state_nx = state;
      ack_a    = 1'b0;
      ack_b    = 1'b0;
      out      = '0;
`ifdef UPLOAD_ARB_RR_EN
      ptr_b_nx = ptr_b;
`endif
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (rdy && (head_a || head_b)) begin
                  if (pick_b) begin
                     ack_b    = 1'b1;
                     out      = in_b;
                     state_nx = ST_B_SEND;
                  end else begin
                     ack_a    = 1'b1;
                     out      = in_a;
                     state_nx = ST_A_SEND;
                  end
               end
            end
            ST_A_SEND: begin
               if (rdy && v_a && (in_a.ctrl != CTRL_NONE)) begin
                  ack_a = 1'b1;
                  out   = in_a;
                  if (in_a.ctrl == CTRL_TAIL) begin
                     state_nx = ST_IDLE;
`ifdef UPLOAD_ARB_RR_EN
                     ptr_b_nx = 1'b1;
`endif
                  end
               end
            end
            ST_B_SEND: begin
               if (rdy && v_b && (in_b.ctrl != CTRL_NONE)) begin
                  ack_b = 1'b1;
                  out   = in_b;
                  if (in_b.ctrl == CTRL_TAIL) begin
                     state_nx = ST_IDLE;
`ifdef UPLOAD_ARB_RR_EN
                     ptr_b_nx = 1'b0;
`endif
                  end
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   assign v = ack_a | ack_b;

endmodule

// File: rtl/upload_arbiter.sv
// Upload arbiter: routes ic/dc/mem packets onto the req and rep rings with a sticky protocol-error flag.
// Define UPLOAD_ARB_RR_EN for round-robin tie-break; default is fixed priority (req dc>ic, rep mem>dc).
module upload_arbiter
   import upload_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              v_ic,
   input  logic [FLIT_W-1:0] flit_ic,
   input  logic [CTRL_W-1:0] ctrl_ic,
   output logic              ack_ic,
   input  logic              v_dc,
   input  logic [FLIT_W-1:0] flit_dc,
   input  logic [CTRL_W-1:0] ctrl_dc,
   output logic              ack_dc,
   input  logic              v_mem,
   input  logic [FLIT_W-1:0] flit_mem,
   input  logic [CTRL_W-1:0] ctrl_mem,
   output logic              ack_mem,
   input  logic              req_rdy,
   output logic              v_req,
   output logic [FLIT_W-1:0] flit_req,
   output logic [CTRL_W-1:0] ctrl_req,
   input  logic              rep_rdy,
   output logic              v_rep,
   output logic [FLIT_W-1:0] flit_rep,
   output logic [CTRL_W-1:0] ctrl_rep,
   output logic              err_proto
);

   flit_t              in_ic, in_dc, in_mem, out_req, out_rep;
   logic [STATE_W-1:0] req_state, rep_state;
   logic               req_ack_ic, req_ack_dc, rep_ack_dc, rep_ack_mem;
   logic               lock_ic, lock_dc, lock_mem, dc_on_req, dc_on_rep;
   logic               head_ic, head_dc, head_mem, dc_to_rep;
   logic               stray_ic, stray_dc, stray_mem, err_set;

   assign in_ic  = '{ctrl: ctrl_ic,  data: flit_ic};
   assign in_dc  = '{ctrl: ctrl_dc,  data: flit_dc};
   assign in_mem = '{ctrl: ctrl_mem, data: flit_mem};

   assign dc_on_req = (req_state == REQ_DC_SEND);
   assign dc_on_rep = (rep_state == REP_DC_SEND);
   assign lock_ic   = (req_state == REQ_IC_SEND);
   assign lock_dc   = dc_on_req | dc_on_rep;
   assign lock_mem  = (rep_state == REP_MEM_SEND);

   assign head_ic   = v_ic  && (ctrl_ic  == CTRL_HEAD);
   assign head_dc   = v_dc  && (ctrl_dc  == CTRL_HEAD);
   assign head_mem  = v_mem && (ctrl_mem == CTRL_HEAD);
   assign dc_to_rep = flit_dc[DC_ROUTE_BIT];

   // A dc head is only offered to the channel dc is not already locked on.
   chan_arb2 #(.TIE_B(1'b1)) u_req (
      .clk    (clk),
      .rst    (rst),
      .head_a (head_ic),
      .head_b (head_dc && !dc_to_rep && !dc_on_rep),
      .v_a    (v_ic),
      .v_b    (v_dc),
      .in_a   (in_ic),
      .in_b   (in_dc),
      .rdy    (req_rdy),
      .ack_a  (req_ack_ic),
      .ack_b  (req_ack_dc),
      .v      (v_req),
      .out    (out_req),
      .state  (req_state)
   );

   chan_arb2 #(.TIE_B(1'b1)) u_rep (
      .clk    (clk),
      .rst    (rst),
      .head_a (head_dc && dc_to_rep && !dc_on_req),
      .head_b (head_mem),
      .v_a    (v_dc),
      .v_b    (v_mem),
      .in_a   (in_dc),
      .in_b   (in_mem),
      .rdy    (rep_rdy),
      .ack_a  (rep_ack_dc),
      .ack_b  (rep_ack_mem),
      .v      (v_rep),
      .out    (out_rep),
      .state  (rep_state)
   );

   assign flit_req = out_req.data;
   assign ctrl_req = out_req.ctrl;
   assign flit_rep = out_rep.data;
   assign ctrl_rep = out_rep.ctrl;

   // Body/tail from an unlocked requester is consumed and flagged.
   assign stray_ic  = !rst && v_ic  && is_stray(ctrl_ic)  && !lock_ic;
   assign stray_dc  = !rst && v_dc  && is_stray(ctrl_dc)  && !lock_dc;
   assign stray_mem = !rst && v_mem && is_stray(ctrl_mem) && !lock_mem;

   assign ack_ic  = req_ack_ic | stray_ic;
   assign ack_dc  = req_ack_dc | rep_ack_dc | stray_dc;
   assign ack_mem = rep_ack_mem | stray_mem;

   assign err_set = stray_ic | stray_dc | stray_mem
                  | (lock_ic  && v_ic  && (ctrl_ic  == CTRL_NONE))
                  | (lock_dc  && v_dc  && (ctrl_dc  == CTRL_NONE))
                  | (lock_mem && v_mem && (ctrl_mem == CTRL_NONE));

   always_ff @(posedge clk) begin
      if (rst)          err_proto <= 1'b0;
      else if (err_set) err_proto <= 1'b1;
   end

endmodule

// File: doc/upload_arbiter.md
UPLOAD_ARBITER -- requirements
Module: upload_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous, active-high reset (clock clk).
REQ-002 SHALL have source ports per requester X in {ic, dc, mem}: v_X  in  1  flit valid; flit_X  in  16  flit; ctrl_X  in  2  01 head / 10 body / 11 tail / 00 none; ack_X  out  1  flit accepted this cycle.
REQ-003 SHALL have network ports per channel C in {req, rep}: C_rdy  in  1  ring input can take a flit; v_C  out  1  flit valid; flit_C  out  16  flit; ctrl_C  out  2  ctrl; err_proto  out  1  sticky protocol-error flag.

Function
REQ-004 SHALL route ic packets to req only, mem packets to rep only, and dc packets to rep when the dc head flit_dc[15]=1, else to req.
REQ-005 SHALL run one FSM per channel: req states IDLE, IC_SEND, DC_SEND; rep states IDLE, DC_SEND, MEM_SEND.
REQ-006 SHALL grant in IDLE only to a requester with v_X=1, ctrl_X=01 and the matching channel; the head is forwarded and ack_X asserted in the same cycle when C_rdy=1 (zero-cycle latency), and the FSM moves to X_SEND.
REQ-007 SHALL make no grant in IDLE when C_rdy=0; the state does not change.
REQ-008 SHALL in X_SEND forward flit_X/ctrl_X and assert ack_X only in cycles with v_X=1 and C_rdy=1; other requesters stay un-acked.
REQ-009 SHALL return to IDLE on the cycle a tail (ctrl 11) is transferred; a new head is grantable from the next cycle.
REQ-010 SHALL drive v_C=0, flit_C=16'h0000 and ctrl_C=2'b00 in every cycle with no transfer.
REQ-011 SHALL hold a granted packet until its tail is transferred; no pre-emption.
REQ-012 SHALL drop a non-head flit (ctrl 10/11) that arrives in IDLE for a requester not locked on any channel: ack_X=1 (consumed) and err_proto set.
REQ-013 SHALL set err_proto when ctrl_X=00 with v_X=1 during X_SEND; that flit is not acked.
REQ-014 SHALL keep err_proto set until reset.
REQ-015 SHALL ignore dc on channel B while dc is locked on channel A.

Reset
REQ-016 SHALL on rst force both FSMs to IDLE, all ack_X and v_C to 0, all flit_C and ctrl_C to 0, err_proto to 0, and round-robin pointers to their initial value; reset mid-packet abandons the packet without flushing.

Configuration
REQ-017 SHALL, with UPLOAD_ARB_RR_EN defined, use a 1-bit round-robin pointer per channel; on a tie in IDLE the pointer's requester wins, and the pointer flips to the other requester on each tail transfer of the winner (initial pointer: req->dc, rep->mem).
REQ-018 SHALL, without UPLOAD_ARB_RR_EN, use fixed priority on ties: req dc>ic, rep mem>dc; no pointer state is implemented.

Structure
REQ-019 SHALL place in the shared package: ctrl encodings (HEAD=01, BODY=10, TAIL=11, NONE=00), the dc route bit index (15), and the FSM state encodings (one-hot).
REQ-020 SHALL implement each channel as one instance of a sub-module chan_arb2 (two-requester packet-locking arbiter) parameterised by tie-break; the top level contains routing, dc exclusion and err_proto logic.

Verification
REQ-021 SHALL cover: ic head 01 then tail 11 with req_rdy=1 -> v_req=1 for 2 cycles, ack_ic=1 both cycles, state IC_SEND then IDLE.
REQ-022 SHALL cover: dc head flit 16'h8001 ctrl 01 with rep_rdy=1 -> appears on rep, not req; ack_dc=1.
REQ-023 SHALL cover: ic and dc heads for req in the same cycle, twice back-to-back -> RR_EN: dc then ic; without RR_EN: dc both times.
REQ-024 SHALL cover: mem packet of 4 flits with rep_rdy low for 3 cycles mid-packet -> no ack or v_rep during stall; dc rep head is blocked until mem's tail transfers.
REQ-025 SHALL cover: ic ctrl 10 with v_ic=1 in IDLE -> ack_ic=1, v_req=0, err_proto=1 and it stays 1 until rst.
REQ-026 SHALL cover: rst asserted during a dc req body -> next cycle all outputs 0, state IDLE, a fresh ic head is granted immediately.
